// File: rtl/pulse_handshake_tx.sv
// Two-phase event sender: queues input pulses and launches them one per acknowledged req_toggle transition.
// Empty-queue pulse launches at the sampling edge; further pulses wait behind the counter and drop (overflow) once it is full.
module pulse_handshake_tx #(
  parameter int CNT_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_pulse,
  input  logic                 ack_toggle,
  output logic                 req_toggle,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pending_cnt,
  output logic                 overflow
);

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_last;
  logic                   ack_sync;
  logic                   ack_seen;
  logic                   have_work;
  logic                   launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_toggle};
    end
  end

  assign ack_sync  = ack_sync_q[SYNC_STAGES-1];
  assign ack_seen  = ack_sync ^ ack_last;
  assign have_work = (pending_cnt != CNT_ZERO) || in_pulse;
  // An ack arriving while IDLE is a protocol violation and simply never gates a launch.
  assign launch    = (state == IDLE) ? have_work : (ack_seen && have_work);
  assign busy      = (state == WAIT_ACK) || (pending_cnt != CNT_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack_last    <= 1'b0;
      req_toggle  <= 1'b0;
      pending_cnt <= CNT_ZERO;
      overflow    <= 1'b0;
    end else begin
      ack_last <= ack_sync;
      overflow <= 1'b0;

      if (launch) begin
        req_toggle <= ~req_toggle;
        state      <= WAIT_ACK;
      end else if ((state == WAIT_ACK) && ack_seen) begin
        state <= IDLE;
      end

      // Launch drains the queue first; with an empty queue it bypasses the same-cycle pulse.
      if (launch) begin
        if ((pending_cnt != CNT_ZERO) && !in_pulse) begin
          pending_cnt <= pending_cnt - CNT_ONE;
        end
      end else if (in_pulse) begin
        if (pending_cnt == CNT_MAX) begin
          overflow <= 1'b1;
        end else begin
          pending_cnt <= pending_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule
